fir_mac_scheduler: RTL and testbench

Time-multiplexes one symmetric 22-tap FIR multiply-accumulate datapath between the RED and IR sample streams of the pulse-oximeter front end. The block accepts 8-bit ADC samples from each channel over valid/ready handshakes and keeps a 22-entry delay line per channel. A round-robin arbiter picks which pending sample is processed next, and an FSM sequences 11 pre-add/multiply/accumulate steps to produce a 20-bit filtered result per channel. It sits between the LED/ADC sampling sequencer and the SpO2/heart-rate post-processing.

---
 rtl/fir_sched_pkg.sv | 30 +++
 rtl/fir_mac_scheduler_if.sv | 41 ++++
 rtl/fir_delay_line.sv | 34 +++
 rtl/fir_mac_scheduler.sv | 209 ++++++++++++++++++++
 tb/tb_fir_mac_scheduler.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_sched_pkg.sv
// Shared constants and types for the RED/IR FIR MAC scheduler.
// Latency: n/a (declarations only). Backpressure: n/a.
package fir_sched_pkg;

    localparam int NPAIR   = 11;
    localparam int COEFF_W = 8;

    // Symmetric half of the 22-tap response, index 0 = outermost tap pair.
    localparam logic [0:NPAIR-1][COEFF_W-1:0] COEFF = {
        8'd2,  8'd10, 8'd16, 8'd28,  8'd43, 8'd60,
        8'd78, 8'd95, 8'd111, 8'd122, 8'd128
    };

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        MAC,
        DONE
    } state_e;

    typedef enum logic {
        CH_RED,
        CH_IR
    } ch_e;

    function automatic ch_e other_ch(input ch_e c);
        return (c == CH_RED) ? CH_IR : CH_RED;
    endfunction

endpackage

// File: rtl/fir_mac_scheduler_if.sv
// Sample-in / result-out bundle of the FIR MAC scheduler; overrun flags exist only with FIR_MAC_SCHED_OVERRUN_EN.
// Latency: n/a (wiring only). Backpressure: red_ready/ir_ready gate the sample handshakes.
interface fir_mac_scheduler_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 20
);
    logic              red_valid;
    logic [DATA_W-1:0] red_data;
    logic              red_ready;
    logic              ir_valid;
    logic [DATA_W-1:0] ir_data;
    logic              ir_ready;
    logic [OUT_W-1:0]  red_out;
    logic              red_out_valid;
    logic [OUT_W-1:0]  ir_out;
    logic              ir_out_valid;
    logic              busy;
`ifdef FIR_MAC_SCHED_OVERRUN_EN
    logic              red_overrun;
    logic              ir_overrun;
`endif

    modport master (
        output red_valid, red_data, ir_valid, ir_data,
        input  red_ready, ir_ready, red_out, red_out_valid,
        input  ir_out, ir_out_valid, busy
`ifdef FIR_MAC_SCHED_OVERRUN_EN
        , input red_overrun, ir_overrun
`endif
    );

    modport slave (
        input  red_valid, red_data, ir_valid, ir_data,
        output red_ready, ir_ready, red_out, red_out_valid,
        output ir_out, ir_out_valid, busy
`ifdef FIR_MAC_SCHED_OVERRUN_EN
        , output red_overrun, ir_overrun
`endif
    );

endinterface

// File: rtl/fir_delay_line.sv
// TAPS-deep sample shift register with parallel read-out; element 0 is the newest sample.
// Latency: shifts on the edge where shift_en is high. Backpressure: none, holds when shift_en is low.
module fir_delay_line #(
    parameter int TAPS   = 22,
    parameter int DATA_W = 8
) (
    input  logic                     CLK_Filter,
    input  logic                     rst_n,
    input  logic                     shift_en,
    input  logic [DATA_W-1:0]        din,
    output logic [TAPS*DATA_W-1:0]   taps_flat
);

    logic [TAPS-1:0][DATA_W-1:0] line_q;
    logic [TAPS-1:0][DATA_W-1:0] line_d;

    always_comb begin
        line_d = line_q;
        if (shift_en) begin
            line_d = {line_q[TAPS-2:0], din};
        end
    end

    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign taps_flat = line_q;

endmodule

// File: rtl/fir_mac_scheduler.sv
// One symmetric 22-tap FIR MAC shared round-robin between RED and IR; optional sticky overrun flags via FIR_MAC_SCHED_OVERRUN_EN.
// Latency: result pulse 14 edges after acceptance from idle, 13-cycle service period. Backpressure: one pending slot per channel, ready = !pending.
module fir_mac_scheduler
    import fir_sched_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 20,
    parameter int TAPS   = 22
) (
    input  logic                 CLK_Filter,
    input  logic                 rst_n,
    fir_mac_scheduler_if.slave   bus
);

    localparam int IDX_W  = $clog2(TAPS);
    localparam int K_W    = $clog2(NPAIR);
    localparam int PRE_W  = DATA_W + 1;
    localparam int PROD_W = DATA_W + 1 + COEFF_W;

    state_e              state_q, state_d;
    ch_e                 sel_q, sel_d;
    ch_e                 last_q, last_d;
    ch_e                 pick;
    logic [K_W-1:0]      k_q, k_d;
    logic [OUT_W-1:0]    acc_q, acc_d;
    logic                red_pend_q, red_pend_d;
    logic                ir_pend_q, ir_pend_d;
    logic [DATA_W-1:0]   red_smp_q, red_smp_d;
    logic [DATA_W-1:0]   ir_smp_q, ir_smp_d;
    logic [OUT_W-1:0]    red_out_q, red_out_d;
    logic [OUT_W-1:0]    ir_out_q, ir_out_d;
    logic                red_out_valid_q, red_out_valid_d;
    logic                ir_out_valid_q, ir_out_valid_d;
    logic                busy_q, busy_d;

    logic [TAPS-1:0][DATA_W-1:0] red_taps;
    logic [TAPS-1:0][DATA_W-1:0] ir_taps;
    logic                red_shift, ir_shift;
    logic [IDX_W-1:0]    lo_idx, hi_idx;
    logic [DATA_W-1:0]   tap_lo, tap_hi;
    logic [PRE_W-1:0]    pre_sum;
    logic [PROD_W-1:0]   prod;

    assign red_shift = (state_q == LOAD) && (sel_q == CH_RED);
    assign ir_shift  = (state_q == LOAD) && (sel_q == CH_IR);

    fir_delay_line #(.TAPS(TAPS), .DATA_W(DATA_W)) u_red_line (
        .CLK_Filter (CLK_Filter),
        .rst_n      (rst_n),
        .shift_en   (red_shift),
        .din        (red_smp_q),
        .taps_flat  (red_taps)
    );

    fir_delay_line #(.TAPS(TAPS), .DATA_W(DATA_W)) u_ir_line (
        .CLK_Filter (CLK_Filter),
        .rst_n      (rst_n),
        .shift_en   (ir_shift),
        .din        (ir_smp_q),
        .taps_flat  (ir_taps)
    );

    // Pair k folds tap k with its mirror TAPS-1-k before the single multiply.
    assign lo_idx  = IDX_W'(k_q);
    assign hi_idx  = IDX_W'(TAPS - 1) - lo_idx;
    assign tap_lo  = (sel_q == CH_RED) ? red_taps[lo_idx] : ir_taps[lo_idx];
    assign tap_hi  = (sel_q == CH_RED) ? red_taps[hi_idx] : ir_taps[hi_idx];
    assign pre_sum = {1'b0, tap_lo} + {1'b0, tap_hi};
    assign prod    = PROD_W'(pre_sum) * PROD_W'(COEFF[k_q]);

    // Alternate only on a tie; a lone pending channel is always taken.
    assign pick = (red_pend_q && ir_pend_q) ? other_ch(last_q)
                : (red_pend_q ? CH_RED : CH_IR);

    always_comb begin
        state_d         = state_q;
        sel_d           = sel_q;
        last_d          = last_q;
        k_d             = k_q;
        acc_d           = acc_q;
        red_pend_d      = red_pend_q;
        ir_pend_d       = ir_pend_q;
        red_smp_d       = red_smp_q;
        ir_smp_d        = ir_smp_q;
        red_out_d       = red_out_q;
        ir_out_d        = ir_out_q;
        red_out_valid_d = 1'b0;
        ir_out_valid_d  = 1'b0;

        if (bus.red_valid && !red_pend_q) begin
            red_pend_d = 1'b1;
            red_smp_d  = bus.red_data;
        end
        if (bus.ir_valid && !ir_pend_q) begin
            ir_pend_d = 1'b1;
            ir_smp_d  = bus.ir_data;
        end

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    if (sel_q == CH_RED) begin
                        red_out_d       = acc_q;
                        red_out_valid_d = 1'b1;
                    end else begin
                        ir_out_d       = acc_q;
                        ir_out_valid_d = 1'b1;
                    end
                end
                if (red_pend_q || ir_pend_q) begin
                    state_d = LOAD;
                    sel_d   = pick;
                    last_d  = pick;
                    if (pick == CH_RED) begin
                        red_pend_d = 1'b0;
                    end else begin
                        ir_pend_d = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                acc_d   = '0;
                k_d     = '0;
                state_d = MAC;
            end
            MAC: begin
                acc_d = acc_q + OUT_W'(prod);
                k_d   = k_q + 1'b1;
                if (k_q == K_W'(NPAIR - 1)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            sel_q           <= CH_RED;
            last_q          <= CH_IR;
            k_q             <= '0;
            acc_q           <= '0;
            red_pend_q      <= 1'b0;
            ir_pend_q       <= 1'b0;
            red_smp_q       <= '0;
            ir_smp_q        <= '0;
            red_out_q       <= '0;
            ir_out_q        <= '0;
            red_out_valid_q <= 1'b0;
            ir_out_valid_q  <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            sel_q           <= sel_d;
            last_q          <= last_d;
            k_q             <= k_d;
            acc_q           <= acc_d;
            red_pend_q      <= red_pend_d;
            ir_pend_q       <= ir_pend_d;
            red_smp_q       <= red_smp_d;
            ir_smp_q        <= ir_smp_d;
            red_out_q       <= red_out_d;
            ir_out_q        <= ir_out_d;
            red_out_valid_q <= red_out_valid_d;
            ir_out_valid_q  <= ir_out_valid_d;
            busy_q          <= busy_d;
        end
    end

    assign bus.red_ready     = !red_pend_q;
    assign bus.ir_ready      = !ir_pend_q;
    assign bus.red_out       = red_out_q;
    assign bus.ir_out        = ir_out_q;
    assign bus.red_out_valid = red_out_valid_q;
    assign bus.ir_out_valid  = ir_out_valid_q;
    assign bus.busy          = busy_q;

`ifdef FIR_MAC_SCHED_OVERRUN_EN
    logic red_ov_q, red_ov_d;
    logic ir_ov_q, ir_ov_d;

    // Sticky: a source offering into a full slot has lost timing, only reset clears it.
    always_comb begin
        red_ov_d = red_ov_q | (bus.red_valid & red_pend_q);
        ir_ov_d  = ir_ov_q  | (bus.ir_valid  & ir_pend_q);
    end

    always_ff @(posedge CLK_Filter or negedge rst_n) begin
        if (!rst_n) begin
            red_ov_q <= 1'b0;
            ir_ov_q  <= 1'b0;
        end else begin
            red_ov_q <= red_ov_d;
            ir_ov_q  <= ir_ov_d;
        end
    end

    assign bus.red_overrun = red_ov_q;
    assign bus.ir_overrun  = ir_ov_q;
`endif

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed + randomized bench for fir_mac_scheduler against a direct-convolution reference model.
module tb_fir_mac_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fir_mac_scheduler_if bus ();

    fir_mac_scheduler dut (
        .CLK_Filter (clk),
        .rst_n      (rst_n),
        .bus        (bus)
    );

    int checks = 0;
    int errors = 0;

    int red_hist[22];
    int ir_hist[22];
    int exp_red[$];
    int exp_ir[$];
    int red_pulses = 0;
    int ir_pulses = 0;
    int red_acc = 0;
    int ir_acc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full 22-tap impulse response, mirrored from the published half-table.
    function automatic int tap_coeff(input int j);
        int half[11] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128};
        return half[(j < 11) ? j : 21 - j];
    endfunction

    function automatic int conv(input int hist[22]);
        int s = 0;
        for (int j = 0; j < 22; j++) s += tap_coeff(j) * hist[j];
        return s;
    endfunction

    // Reference model: records accepted samples and checks every result pulse in channel order.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.red_out_valid === 1'b1) begin
                red_pulses++;
                if (exp_red.size() == 0) check("red_unexpected_pulse", 32'd1, 32'd0);
                else check("red_out_value", 32'(bus.red_out), 32'(exp_red.pop_front()));
            end
            if (bus.ir_out_valid === 1'b1) begin
                ir_pulses++;
                if (exp_ir.size() == 0) check("ir_unexpected_pulse", 32'd1, 32'd0);
                else check("ir_out_value", 32'(bus.ir_out), 32'(exp_ir.pop_front()));
            end
            if (bus.red_valid && bus.red_ready) begin
                for (int i = 21; i > 0; i--) red_hist[i] = red_hist[i-1];
                red_hist[0] = int'(bus.red_data);
                exp_red.push_back(conv(red_hist));
                red_acc++;
            end
            if (bus.ir_valid && bus.ir_ready) begin
                for (int i = 21; i > 0; i--) ir_hist[i] = ir_hist[i-1];
                ir_hist[0] = int'(bus.ir_data);
                exp_ir.push_back(conv(ir_hist));
                ir_acc++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_model();
        for (int i = 0; i < 22; i++) begin
            red_hist[i] = 0;
            ir_hist[i]  = 0;
        end
        exp_red.delete();
        exp_ir.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.red_valid = 1'b0;
        bus.ir_valid  = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_red_out"}, 32'(bus.red_out), 32'd0);
        check({tag, "_ir_out"}, 32'(bus.ir_out), 32'd0);
        check({tag, "_red_out_valid"}, 32'(bus.red_out_valid), 32'd0);
        check({tag, "_ir_out_valid"}, 32'(bus.ir_out_valid), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_red_ready"}, 32'(bus.red_ready), 32'd1);
        check({tag, "_ir_ready"}, 32'(bus.ir_ready), 32'd1);
`ifdef FIR_MAC_SCHED_OVERRUN_EN
        check({tag, "_red_overrun"}, 32'(bus.red_overrun), 32'd0);
        check({tag, "_ir_overrun"}, 32'(bus.ir_overrun), 32'd0);
`endif
    endtask

    // Entered and left at #1 after a rising edge.
    task automatic send_red(input logic [7:0] d);
        bit ok = 0;
        bus.red_valid = 1'b1;
        bus.red_data  = d;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (bus.red_ready) begin
                @(posedge clk); #1;
                ok = 1;
            end
        end
        bus.red_valid = 1'b0;
        check("send_red_accepted", 32'(ok), 32'd1);
    endtask

    task automatic send_ir(input logic [7:0] d);
        bit ok = 0;
        bus.ir_valid = 1'b1;
        bus.ir_data  = d;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            if (bus.ir_ready) begin
                @(posedge clk); #1;
                ok = 1;
            end
        end
        bus.ir_valid = 1'b0;
        check("send_ir_accepted", 32'(ok), 32'd1);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int c = 0; c < 600 && !done; c++) begin
            @(negedge clk);
            if (!bus.busy && bus.red_ready && bus.ir_ready &&
                exp_red.size() == 0 && exp_ir.size() == 0) done = 1;
        end
        check("drain_to_idle", 32'(done), 32'd1);
        @(posedge clk); #1;
    endtask

    // Both channels offered on the same edge E0; first winner pulses after E14, second after E27.
    task automatic tie_run(input bit red_first);
        bus.red_valid = 1'b1;
        bus.ir_valid  = 1'b1;
        bus.red_data  = 8'($urandom);
        bus.ir_data   = 8'($urandom);
        @(posedge clk); #1;
        bus.red_valid = 1'b0;
        bus.ir_valid  = 1'b0;
        for (int n = 0; n <= 28; n++) begin
            @(negedge clk);
            check("tie_red_pulse_time", 32'(bus.red_out_valid), 32'(red_first ? (n == 14) : (n == 27)));
            check("tie_ir_pulse_time", 32'(bus.ir_out_valid), 32'(red_first ? (n == 27) : (n == 14)));
        end
        @(posedge clk); #1;
    endtask

    task automatic impulse_red(input string tag);
        red_pulses = 0;
        ir_pulses  = 0;
        send_red(8'd1);
        for (int i = 0; i < 21; i++) send_red(8'd0);
        wait_idle();
        check({tag, "_red_pulses"}, 32'(red_pulses), 32'd22);
        check({tag, "_ir_pulses"}, 32'(ir_pulses), 32'd0);
        check({tag, "_ir_out"}, 32'(bus.ir_out), 32'd0);
        check({tag, "_red_last"}, 32'(bus.red_out), 32'd2);
    endtask

    initial begin
        int red_low;
        bus.red_valid = 1'b0;
        bus.red_data  = '0;
        bus.ir_valid  = 1'b0;
        bus.ir_data   = '0;
        clear_model();

        // Reset state
        @(negedge clk);
        check_quiet("in_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_quiet("after_reset");
        @(posedge clk); #1;

        // Latency from idle: sample 100 -> 200 pulsed after E14
        bus.red_valid = 1'b1;
        bus.red_data  = 8'd100;
        @(posedge clk); #1;
        bus.red_valid = 1'b0;
        for (int n = 0; n <= 16; n++) begin
            @(negedge clk);
            check("lat_red_out_valid", 32'(bus.red_out_valid), 32'(n == 14));
            check("lat_busy", 32'(bus.busy), 32'(n >= 1 && n <= 13));
            check("lat_red_ready", 32'(bus.red_ready), 32'(n != 0));
            if (n == 14) check("lat_red_out", 32'(bus.red_out), 32'd200);
        end
        @(posedge clk); #1;

        // Impulse on RED
        do_reset();
        impulse_red("impulse");

        // Step on IR
        red_pulses = 0;
        ir_pulses  = 0;
        for (int i = 0; i < 25; i++) send_ir(8'd255);
        wait_idle();
        check("step_ir_pulses", 32'(ir_pulses), 32'd25);
        check("step_ir_final", 32'(bus.ir_out), 32'd353430);
        check("step_red_pulses", 32'(red_pulses), 32'd0);

        // Ties: RED first after reset; after a lone RED, the next tie goes to IR
        do_reset();
        tie_run(1'b1);
        wait_idle();
        send_red(8'($urandom));
        wait_idle();
        tie_run(1'b0);
        wait_idle();

        // Backpressure with RED held valid and random IR traffic
        red_pulses = 0;
        ir_pulses  = 0;
        red_acc    = 0;
        ir_acc     = 0;
        red_low    = 0;
        for (int c = 0; c < 400; c++) begin
            bus.red_valid = 1'b1;
            bus.red_data  = 8'($urandom);
            bus.ir_valid  = 1'($urandom_range(0, 1));
            bus.ir_data   = 8'($urandom);
            @(negedge clk);
            if (!bus.red_ready) red_low++;
            @(posedge clk); #1;
        end
        bus.red_valid = 1'b0;
        bus.ir_valid  = 1'b0;
        wait_idle();
        check("bp_red_ready_low_seen", 32'(red_low > 300), 32'd1);
        check("bp_red_pulse_count", 32'(red_pulses), 32'(red_acc));
        check("bp_ir_pulse_count", 32'(ir_pulses), 32'(ir_acc));
`ifdef FIR_MAC_SCHED_OVERRUN_EN
        check("bp_red_overrun", 32'(bus.red_overrun), 32'd1);
`endif

        // Reset during MAC: accept at E0, reset just after E6
        do_reset();
        bus.red_valid = 1'b1;
        bus.red_data  = 8'd77;
        @(posedge clk); #1;
        bus.red_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1 rst_n = 1'b0;
        clear_model();
        @(negedge clk);
        check_quiet("mid_mac_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            check("post_reset_no_red_pulse", 32'(bus.red_out_valid), 32'd0);
            check("post_reset_idle", 32'(bus.busy), 32'd0);
        end
        @(posedge clk); #1;
        impulse_red("impulse_after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
